// File: rtl/dram_responder.sv
// rtl/dram_responder.sv - CPU data-memory responder: byte-strobed array, 1-cycle write-first read, post-reset clear
// Optional MMIO window (cycle counter + output register) enabled by DRAM_MMIO_EN.
module dram_responder #(
  parameter int          DEPTH     = 65536,
  parameter logic [15:0] MMIO_BASE = 16'hFFF0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] a,
  input  logic [3:0]  we,
  input  logic [31:0] din,
  output logic [31:0] spo,
  output logic        init_done,
  output logic        addr_err,
  output logic [31:0] mmio_out
);

  localparam int              AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [16:0]     DEPTH_W  = 17'(DEPTH);
  localparam logic [AW-1:0]   LAST_IDX = AW'(DEPTH - 1);
  localparam logic [15:0]     MMIO_OUT_ADDR = MMIO_BASE + 16'd1;
`ifdef DRAM_MMIO_EN
  localparam bit              MMIO_ON  = 1'b1;
`else
  localparam bit              MMIO_ON  = 1'b0;
`endif

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_READY = 1'b1
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [AW-1:0] r_clr_idx;
  logic [AW-1:0] w_clr_idx_nxt;

  logic [31:0]   r_mem [DEPTH];
  logic [31:0]   r_spo;
  logic [31:0]   w_spo_nxt;
  logic          r_addr_err;

  logic          w_ready;
  logic [AW-1:0] w_idx;
  logic          w_oor;
  logic          w_sel_cnt;
  logic          w_sel_out;
  logic          w_arr_acc;
  logic [31:0]   w_cnt_val;
  logic [31:0]   w_mmio_val;

  function automatic logic [31:0] f_merge(input logic [31:0] old_w,
                                          input logic [3:0]  lanes,
                                          input logic [31:0] new_w);
    logic [31:0] res;
    res = old_w;
    for (int i = 0; i < 4; i++) begin
      if (lanes[i]) res[8*i +: 8] = new_w[8*i +: 8];
    end
    return res;
  endfunction

  assign w_ready   = (r_state == S_READY);
  assign w_idx     = a[AW-1:0];
  assign w_oor     = ({1'b0, a} >= DEPTH_W);
  // The MMIO window wins over both the array and the range check.
  assign w_sel_cnt = MMIO_ON && w_ready && (a == MMIO_BASE);
  assign w_sel_out = MMIO_ON && w_ready && (a == MMIO_OUT_ADDR);
  assign w_arr_acc = w_ready && !w_sel_cnt && !w_sel_out && !w_oor;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_CLEAR;
      r_clr_idx <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_idx <= w_clr_idx_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_clr_idx_nxt = r_clr_idx;
    if (r_state == S_CLEAR) begin
      w_clr_idx_nxt = r_clr_idx + 1'b1;
      if (r_clr_idx == LAST_IDX) begin
        w_state_nxt   = S_READY;
        w_clr_idx_nxt = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (r_state == S_CLEAR) begin
      r_mem[r_clr_idx] <= 32'h0;
    end else if (w_arr_acc) begin
      for (int i = 0; i < 4; i++) begin
        if (we[i]) r_mem[w_idx][8*i +: 8] <= din[8*i +: 8];
      end
    end
  end

  always_comb begin
    w_spo_nxt = 32'h0;
    if (w_sel_cnt) begin
      w_spo_nxt = w_cnt_val;
    end else if (w_sel_out) begin
      w_spo_nxt = f_merge(w_mmio_val, we, din);
    end else if (w_arr_acc) begin
      w_spo_nxt = f_merge(r_mem[w_idx], we, din);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_spo      <= 32'h0;
      r_addr_err <= 1'b0;
    end else begin
      r_spo <= w_spo_nxt;
      if (w_ready && w_oor && !w_sel_cnt && !w_sel_out) r_addr_err <= 1'b1;
    end
  end

`ifdef DRAM_MMIO_EN
  logic [31:0] r_cycle_cnt;
  logic [31:0] r_mmio_out;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cycle_cnt <= 32'h0;
    end else begin
      r_cycle_cnt <= r_cycle_cnt + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mmio_out <= 32'h0;
    end else if (w_sel_out) begin
      r_mmio_out <= f_merge(r_mmio_out, we, din);
    end
  end

  assign w_cnt_val  = r_cycle_cnt;
  assign w_mmio_val = r_mmio_out;
  assign mmio_out   = r_mmio_out;
`else
  assign w_cnt_val  = 32'h0;
  assign w_mmio_val = 32'h0;
  assign mmio_out   = 32'h0;
`endif

  assign spo       = r_spo;
  assign init_done = w_ready;
  assign addr_err  = r_addr_err;

endmodule
